// File: rtl/jtframe_rom_arb.sv
// jtframe_rom_arb -- round-robin ROM request arbiter in front of one SDRAM port.
//
// Up to eight client slots share a single SDRAM read channel. One transaction
// is in flight at a time. Read data lands in a per-slot register that holds
// its value until that slot's next completion.
//
// Optional feature: define JTFRAME_ROM_ARB_CACHE_EN to give every slot a
// one-entry address tag. A repeated read of the last address is then answered
// without touching SDRAM.
//
// Ports
//   clk_rom, rst       SDRAM-domain clock, synchronous active-high reset
//   downloading        ROM download in progress: no new grants
//   slot_req/addr      per-slot request level and address (slot i at [i*AW +: AW])
//   slot_ok/dout       per-slot completion pulse and held read data
//   slot_sel           index of the granted slot (debug)
//   sdram_*            request/ack handshake and address toward the controller
//   data_read/rdy      controller read data and its one-cycle valid pulse
//   loop_rst           controller not ready: aborts the transaction in flight
module jtframe_rom_arb #(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 32
)(
  input  logic                clk_rom,
  input  logic                rst,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic [2:0]          slot_sel,
  output logic                sdram_req,
  input  logic                sdram_ack,
  output logic [AW-1:0]       sdram_addr,
  input  logic [DW-1:0]       data_read,
  input  logic                data_rdy,
  input  logic                loop_rst
);
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} st_t;
  st_t st, st_nxt;

  logic [SLOTS-1:0][AW-1:0] addr_a;
  logic [SLOTS-1:0][DW-1:0] dout_q;
  logic [SW-1:0]            rr_ptr, sel, gidx, cand, rr_nxt;
  logic [SLOTS-1:0]         req_m;
  logic                     found, go, hit, done, wdrawn;

  assign addr_a    = slot_addr;
  assign slot_dout = dout_q;
  assign slot_sel  = 3'(sel);

  // A slot whose slot_ok is high right now is still holding its request by
  // contract; masking it avoids granting the same read a second time.
  assign req_m = slot_req & ~slot_ok;

  // First requesting slot at or after rr_ptr, cyclic.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int k = 0; k < SLOTS; k++) begin
      cand = SW'((int'(rr_ptr) + k) % SLOTS);
      if (!found && req_m[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  assign rr_nxt = (gidx == SW'(SLOTS-1)) ? '0 : gidx + SW'(1);
  assign go     = (st == IDLE) && found && !downloading && !loop_rst;

`ifdef JTFRAME_ROM_ARB_CACHE_EN
  logic [SLOTS-1:0][AW-1:0] tag_q;
  logic [SLOTS-1:0]         tvld;

  assign hit = tvld[gidx] && (tag_q[gidx] == addr_a[gidx]);

  // Tags follow every completed SDRAM read, withdrawn ones included, since
  // the data register was written either way.
  always_ff @(posedge clk_rom) begin
    if (rst) begin
      tag_q <= '0;
      tvld  <= '0;
    end else begin
      if (done) tag_q[sel] <= sdram_addr;
      if (downloading || loop_rst) tvld <= '0;
      else if (done)               tvld[sel] <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    st_nxt = st;
    done   = 1'b0;
    case (st)
      IDLE: if (go && !hit) st_nxt = REQ;
      REQ:
        if (sdram_ack) begin
          // ack and data together: treat as ack followed by data
          if (data_rdy) begin
            st_nxt = IDLE;
            done   = 1'b1;
          end else begin
            st_nxt = WAIT;
          end
        end
      WAIT:
        if (data_rdy) begin
          st_nxt = IDLE;
          done   = 1'b1;
        end
      default: st_nxt = IDLE;
    endcase
    if (loop_rst) begin
      st_nxt = IDLE;
      done   = 1'b0;
    end
  end

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      st         <= IDLE;
      rr_ptr     <= '0;
      sel        <= '0;
      sdram_addr <= '0;
      sdram_req  <= 1'b0;
      slot_ok    <= '0;
      dout_q     <= '0;
      wdrawn     <= 1'b0;
    end else begin
      st        <= st_nxt;
      sdram_req <= (st_nxt == REQ);
      slot_ok   <= '0;
      if (go) begin
        sel    <= gidx;
        rr_ptr <= rr_nxt;
        wdrawn <= 1'b0;
        if (hit) slot_ok[gidx] <= 1'b1;
        else     sdram_addr    <= addr_a[gidx];
      end else if (st != IDLE && !slot_req[sel]) begin
        // remembered so a request that drops and comes back mid-flight
        // still gets no completion pulse for this read
        wdrawn <= 1'b1;
      end
      if (done) begin
        dout_q[sel]  <= data_read;
        slot_ok[sel] <= !wdrawn && slot_req[sel];
      end
    end
  end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Bench for jtframe_rom_arb: behavioural SDRAM controller with configurable
// ack/data latency, well-behaved clients, and scoreboards for both the SDRAM
// addresses issued and the slot completions returned.
module tb_jtframe_rom_arb;
  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam int DW    = 32;

  logic                clk_rom = 1'b0;
  logic                rst, downloading, loop_rst;
  logic [SLOTS-1:0]    slot_req, slot_ok;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS*DW-1:0] slot_dout;
  logic [2:0]          slot_sel;
  logic                sdram_req, sdram_ack, data_rdy;
  logic [AW-1:0]       sdram_addr;
  logic [DW-1:0]       data_read;

  always #5 clk_rom = ~clk_rom;

  jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
    .clk_rom(clk_rom), .rst(rst), .downloading(downloading),
    .slot_req(slot_req), .slot_addr(slot_addr), .slot_ok(slot_ok),
    .slot_dout(slot_dout), .slot_sel(slot_sel), .sdram_req(sdram_req),
    .sdram_ack(sdram_ack), .sdram_addr(sdram_addr), .data_read(data_read),
    .data_rdy(data_rdy), .loop_rst(loop_rst)
  );

  typedef struct { int slot; logic [DW-1:0] data; } exp_t;
  exp_t          exp_q[$];
  logic [AW-1:0] aq[$];

  int checks = 0, errors = 0, req_cnt = 0;
  int ok_cnt[SLOTS] = '{default:0};
  int c_st = 0, c_cnt = 0, ack_lat = 2, data_lat = 4;
  logic [AW-1:0] c_addr = '0;
  bit hold_req = 0, withdraw0 = 0;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    if (a == 22'h001234) return 32'hDEADBEEF;
    return {10'h2A5, a};
  endfunction

  function automatic logic [DW-1:0] dout_of(input int i);
    return slot_dout[i*DW +: DW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    slot_addr[i*AW +: AW] = a;
  endtask

  task automatic expect_rd(input int s, input logic [AW-1:0] a);
    exp_t e;
    e.slot = s; e.data = mem(a);
    exp_q.push_back(e);
    aq.push_back(a);
  endtask

  // One clock: observe DUT outputs, act as clients, then act as controller.
  task automatic tick();
    exp_t e;
    @(negedge clk_rom);
    for (int i = 0; i < SLOTS; i++) begin
      if (slot_ok[i]) begin
        ok_cnt[i]++;
        chk("ok_pending", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("ok_slot", i, e.slot);
          chk("ok_data", dout_of(i), e.data);
        end
        if (hold_req) set_addr(i, slot_addr[i*AW +: AW] + 22'h4);
        else          slot_req[i] = 1'b0;
      end
    end
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    if (loop_rst || rst) c_st = 0;
    else case (c_st)
      0: if (sdram_req) begin
           c_addr = sdram_addr;
           req_cnt++;
           chk("req_pending", 64'(aq.size() > 0), 1);
           if (aq.size() > 0) chk("sdram_addr", sdram_addr, aq.pop_front());
           c_cnt = ack_lat;
           c_st  = 1;
         end
      1: if (c_cnt <= 1) begin
           sdram_ack = 1'b1;
           if (data_lat == 0) begin
             data_rdy = 1'b1; data_read = mem(c_addr); c_st = 0;
           end else begin
             c_cnt = data_lat; c_st = 2;
           end
         end else c_cnt--;
      2: if (c_cnt <= 1) begin
           data_rdy = 1'b1; data_read = mem(c_addr); c_st = 0;
         end else c_cnt--;
      default: c_st = 0;
    endcase
    if (withdraw0 && c_st == 2) slot_req[0] = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) tick();
    chk("done_timeout", exp_q.size(), 0);
    repeat (3) tick();
    chk("addr_q_empty", aq.size(), 0);
  endtask

  initial begin
    int rc, okb;
    rst = 1; downloading = 0; loop_rst = 0; slot_req = '0; slot_addr = '0;
    sdram_ack = 0; data_rdy = 0; data_read = '0;
    repeat (3) tick();
    chk("rst_ok", slot_ok, 0);
    chk("rst_req", sdram_req, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_sel", slot_sel, 0);
    for (int i = 0; i < SLOTS; i++) chk("rst_dout", dout_of(i), 0);
    rst = 0;
    tick();

    // single read, ack after 2, data 4 later
    set_addr(2, 22'h001234); slot_req[2] = 1'b1; expect_rd(2, 22'h001234);
    tick();
    chk("grant_req", sdram_req, 1);
    chk("grant_addr", sdram_addr, 22'h001234);
    chk("grant_sel", slot_sel, 2);
    wait_done();
    chk("single_ok_cnt", ok_cnt[2], 1);
    chk("single_dout", dout_of(2), 32'hDEADBEEF);

    // fairness: all slots held from reset, expected grant order 0,1,2,3,0
    rst = 1; hold_req = 1; slot_req = '1; rc = req_cnt;
    for (int i = 0; i < SLOTS; i++) set_addr(i, 22'h010000 + 22'(i * 256));
    for (int i = 0; i < SLOTS; i++) expect_rd(i, 22'h010000 + 22'(i * 256));
    expect_rd(0, 22'h010004);
    repeat (2) tick();
    rst = 0;
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) tick();
    hold_req = 0; slot_req = '0;
    chk("fair_timeout", exp_q.size(), 0);
    repeat (5) tick();
    chk("fair_req_cnt", req_cnt - rc, 5);

    // abort in REQ, then abort in WAIT, then complete
    ack_lat = 4; data_lat = 4; rc = req_cnt; okb = ok_cnt[1];
    set_addr(1, 22'h005555); slot_req[1] = 1'b1; expect_rd(1, 22'h005555);
    aq.push_back(22'h005555); aq.push_back(22'h005555);
    tick();
    chk("abort_req_hi", sdram_req, 1);
    loop_rst = 1; tick(); loop_rst = 0;
    chk("abort_req_lo", sdram_req, 0);
    for (int i = 0; i < 50 && c_st != 2; i++) tick();
    chk("abort_in_wait", c_st, 2);
    loop_rst = 1; tick(); loop_rst = 0;
    chk("abort_no_ok", slot_ok, 0);
    chk("abort_wait_req", sdram_req, 0);
    wait_done();
    chk("abort_ok_cnt", ok_cnt[1] - okb, 1);
    chk("abort_req_cnt", req_cnt - rc, 3);

    // withdrawal after ack: data still lands, no ok
    ack_lat = 2; data_lat = 3; okb = ok_cnt[0];
    set_addr(0, 22'h000AAA); slot_req[0] = 1'b1; aq.push_back(22'h000AAA); withdraw0 = 1;
    for (int i = 0; i < 100 && !(aq.size() == 0 && c_st == 0); i++) tick();
    withdraw0 = 0;
    repeat (3) tick();
    chk("wd_dout", dout_of(0), mem(22'h000AAA));
    chk("wd_no_ok", ok_cnt[0] - okb, 0);

    // download gating
    downloading = 1;
    set_addr(3, 22'h003300); slot_req[3] = 1'b1; expect_rd(3, 22'h003300);
    repeat (4) begin tick(); chk("dl_no_req", sdram_req, 0); end
    downloading = 0;
    tick();
    chk("dl_resume", sdram_req, 1);
    wait_done();

    // ack and data in the same cycle
    ack_lat = 1; data_lat = 0; rc = req_cnt;
    set_addr(2, 22'h002222); slot_req[2] = 1'b1; expect_rd(2, 22'h002222);
    wait_done();
    chk("ackdata_req_cnt", req_cnt - rc, 1);
    ack_lat = 2; data_lat = 3;

`ifdef JTFRAME_ROM_ARB_CACHE_EN
    begin
      exp_t e;
      set_addr(3, 22'h000100); slot_req[3] = 1'b1; expect_rd(3, 22'h000100);
      wait_done();
      rc = req_cnt;
      e.slot = 3; e.data = mem(22'h000100); exp_q.push_back(e);
      slot_req[3] = 1'b1;
      tick();
      chk("hit_ok", slot_ok[3], 1);
      repeat (3) tick();
      chk("hit_no_sdram", req_cnt - rc, 0);
      chk("hit_q", exp_q.size(), 0);
      downloading = 1; tick(); downloading = 0;
      slot_req[3] = 1'b1; expect_rd(3, 22'h000100);
      wait_done();
      chk("miss_after_dl", req_cnt - rc, 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
